// File: rtl/wormy_sequencer.sv
// Game-flow FSM for the 4x4 worm game: attract, run, death flash; outputs registered, arena_out is a same-cycle mux, no backpressure.
// Define WORMY_SEQ_SCORE_EN to add a SCORE state that shows worm length after the death flash.
module wormy_sequencer #(
  parameter int TICK_DIV    = 256,
  parameter int BASE_PERIOD = 8,
  parameter int MIN_PERIOD  = 2,
  parameter int FLASH_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button_pushed,
  input  logic        game_over,
  input  logic [4:0]  worm_len,
  input  logic [15:0] arena_in,
  output logic        step,
  output logic        game_rst,
  output logic [15:0] arena_out,
  output logic [1:0]  seq_state
);
  localparam int            PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [4:0]    BASE       = 5'(BASE_PERIOD);
  localparam logic [4:0]    MINP       = 5'(MIN_PERIOD);
  localparam logic [4:0]    FLASH_LAST = 5'(2 * FLASH_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DEAD  = 2'd2,
    SCORE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q;
  logic          tick;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [4:0]    flash_q, flash_d;
  logic          sub_q, sub_d;
  logic          phase_q, phase_d;
  logic          step_d, game_rst_d;
  logic [4:0]    half, period;
  logic          step_due;

  assign tick      = (pre_q == PRE_LAST);
  assign seq_state = state_q;

  always_ff @(posedge clk) begin
    if (rst || tick) pre_q <= '0;
    else             pre_q <= pre_q + 1'b1;
  end

  // Clamp without ever forming BASE-half below zero.
  always_comb begin
    half = {1'b0, worm_len[4:1]};
    if (half + MINP > BASE) period = MINP;
    else                    period = BASE - half;
  end

  assign step_due = ({1'b0, cnt_q} == period - 5'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    flash_d = flash_q;
    sub_d   = sub_q;
    phase_d = phase_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (button_pushed) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (tick) begin
          idx_d = idx_q + 4'd1;
        end
      end
      RUN: begin
        if (game_over) begin
          state_d = DEAD;
          flash_d = '0;
          sub_d   = 1'b0;
          phase_d = 1'b1;
        end else if (tick) begin
          if (step_due) begin
            step_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      DEAD: begin
        if (tick) begin
          if (!sub_q) begin
            sub_d = 1'b1;
          end else begin
            sub_d   = 1'b0;
            phase_d = ~phase_q;
            flash_d = flash_q + 5'd1;
            if (flash_q == FLASH_LAST) begin
`ifdef WORMY_SEQ_SCORE_EN
              state_d = SCORE;
              cnt_d   = '0;
`else
              state_d = IDLE;
              idx_d   = '0;
`endif
            end
          end
        end
      end
`ifdef WORMY_SEQ_SCORE_EN
      SCORE: begin
        if (button_pushed || (tick && cnt_q == 4'd15)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    game_rst_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      flash_q  <= '0;
      sub_q    <= 1'b0;
      phase_q  <= 1'b0;
      step     <= 1'b0;
      game_rst <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      flash_q  <= flash_d;
      sub_q    <= sub_d;
      phase_q  <= phase_d;
      step     <= step_d;
      game_rst <= game_rst_d;
    end
  end

`ifdef WORMY_SEQ_SCORE_EN
  logic [15:0] therm;
  always_comb begin
    therm = '0;
    for (int i = 0; i < 16; i++) therm[i] = (5'(i) < worm_len);
  end
`else
  logic unused_len0;
  assign unused_len0 = worm_len[0];
`endif

  always_comb begin
    arena_out = 16'h0000;
    case (state_q)
      IDLE:    arena_out = 16'h0001 << idx_q;
      RUN:     arena_out = arena_in;
      DEAD:    arena_out = phase_q ? arena_in : 16'h0000;
`ifdef WORMY_SEQ_SCORE_EN
      SCORE:   arena_out = therm;
`endif
      default: arena_out = 16'h0000;
    endcase
  end
endmodule

// File: tb/tb_wormy_sequencer.sv
// Bench for wormy_sequencer with TICK_DIV=4: checkpoint tables plus a step-time scoreboard.
module tb_wormy_sequencer;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        button_pushed = 1'b0;
  logic        game_over = 1'b0;
  logic [4:0]  worm_len = 5'd0;
  logic [15:0] arena_in = 16'h0000;
  logic        step, game_rst;
  logic [15:0] arena_out;
  logic [1:0]  seq_state;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int exp_q[$];
  int exp_e;

  typedef struct {
    int          off;
    logic [1:0]  st;
    logic        grst;
    logic [15:0] arena;
    logic        press;
  } chk_t;

  typedef struct {
    logic [4:0] len;
    int         per;
  } per_t;

  wormy_sequencer #(
    .TICK_DIV(TD), .BASE_PERIOD(8), .MIN_PERIOD(2), .FLASH_COUNT(4)
  ) dut (
    .clk(clk), .rst(rst), .button_pushed(button_pushed), .game_over(game_over),
    .worm_len(worm_len), .arena_in(arena_in), .step(step), .game_rst(game_rst),
    .arena_out(arena_out), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  // edge_n tracks posedges since the last reset edge, i.e. the prescaler value mod TD.
  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  always @(negedge clk) begin
    if (step) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL step_unexpected: step seen at edge %0d, none expected", edge_n);
      end else begin
        exp_e = exp_q.pop_front();
        if (exp_e != edge_n) begin
          bad++;
          $display("FAIL step_time: step seen at edge %0d, expected at edge %0d", edge_n, exp_e);
        end
      end
      total++;
      if (game_rst || seq_state != 2'd1) begin
        bad++;
        $display("FAIL step_excl: step=1 with game_rst=%0d seq_state=%0d, need 0 and 1", game_rst, seq_state);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, edge_n);
    end
  endtask

  task automatic goto_edge(input int e);
    if (e < edge_n) begin
      total++;
      bad++;
      $display("FAIL goto: target edge %0d already passed, now %0d", e, edge_n);
    end
    while (edge_n < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // First RUN tick is the first tick edge after the press edge p.
  function automatic int first_step(input int p, input int per);
    int m = p + 1;
    while (m % TD != 0) m++;
    return m + TD * (per - 1);
  endfunction

  task automatic press_at(input int e);
    goto_edge(e - 1);
    button_pushed = 1'b1;
    goto_edge(e);
    button_pushed = 1'b0;
  endtask

  initial begin
    chk_t att[6];
    chk_t fl[11];
    per_t pt[8];
    int p, s, d, x;

    att[0] = '{1,  2'd0, 1'b1, 16'h0001, 1'b0};
    att[1] = '{3,  2'd0, 1'b1, 16'h0001, 1'b0};
    att[2] = '{4,  2'd0, 1'b1, 16'h0002, 1'b0};
    att[3] = '{16, 2'd0, 1'b1, 16'h0010, 1'b0};
    att[4] = '{63, 2'd0, 1'b1, 16'h8000, 1'b0};
    att[5] = '{64, 2'd0, 1'b1, 16'h0001, 1'b0};

    pt[0] = '{5'd14, 2}; pt[1] = '{5'd16, 2}; pt[2] = '{5'd0, 8};  pt[3] = '{5'd9, 4};
    pt[4] = '{5'd12, 2}; pt[5] = '{5'd5, 6};  pt[6] = '{5'd13, 2}; pt[7] = '{5'd11, 3};

    fl[0] = '{0,  2'd2, 1'b0, 16'h3C5A, 1'b0};
    fl[1] = '{7,  2'd2, 1'b0, 16'h3C5A, 1'b0};
    fl[2] = '{8,  2'd2, 1'b0, 16'h0000, 1'b0};
    fl[3] = '{15, 2'd2, 1'b0, 16'h0000, 1'b0};
    fl[4] = '{16, 2'd2, 1'b0, 16'h3C5A, 1'b0};
    fl[5] = '{24, 2'd2, 1'b0, 16'h0000, 1'b0};
    fl[6] = '{30, 2'd2, 1'b0, 16'h0000, 1'b1};
    fl[7] = '{56, 2'd2, 1'b0, 16'h0000, 1'b0};
    fl[8] = '{63, 2'd2, 1'b0, 16'h0000, 1'b0};
`ifdef WORMY_SEQ_SCORE_EN
    fl[9]  = '{64, 2'd3, 1'b0, 16'h001F, 1'b0};
    fl[10] = '{68, 2'd3, 1'b0, 16'h001F, 1'b0};
`else
    fl[9]  = '{64, 2'd0, 1'b1, 16'h0001, 1'b0};
    fl[10] = '{68, 2'd0, 1'b1, 16'h0002, 1'b0};
`endif

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_state", 32'(seq_state), 32'd0);
    chk("rst_grst",  32'(game_rst),  32'd1);
    chk("rst_step",  32'(step),      32'd0);
    chk("rst_arena", 32'(arena_out), 32'h0001);

    for (int i = 0; i < 6; i++) begin
      goto_edge(att[i].off);
      chk("att_state", 32'(seq_state), 32'(att[i].st));
      chk("att_arena", 32'(arena_out), 32'(att[i].arena));
    end

    worm_len = 5'd2;
    arena_in = 16'hA5C3;
    p = edge_n + 1;
    press_at(p);
    chk("start_state", 32'(seq_state), 32'd1);
    chk("start_grst",  32'(game_rst),  32'd0);
    chk("start_arena", 32'(arena_out), 32'hA5C3);
    s = first_step(p, 7);
    exp_q.push_back(s);
    exp_q.push_back(s + 28);
    press_at(s + 9);
    chk("run_press_ignored", 32'(seq_state), 32'd1);
    arena_in = 16'h0F0F;
    #1;
    chk("run_passthru", 32'(arena_out), 32'h0F0F);
    s = s + 28;
    goto_edge(s);

    for (int i = 0; i < 8; i++) begin
      worm_len = pt[i].len;
      exp_q.push_back(s + TD * pt[i].per);
      exp_q.push_back(s + 2 * TD * pt[i].per);
      goto_edge(s + 2 * TD * pt[i].per);
      s = s + 2 * TD * pt[i].per;
    end

    // Collision lands exactly on the edge where a step is due.
    goto_edge(s + TD * 3 - 1);
    game_over = 1'b1;
    d = s + TD * 3;
    goto_edge(d);
    game_over = 1'b0;
    worm_len = 5'd5;
    arena_in = 16'h3C5A;
    for (int i = 0; i < 11; i++) begin
      if (fl[i].press) press_at(d + fl[i].off);
      else             goto_edge(d + fl[i].off);
      #1;
      chk("flash_state", 32'(seq_state), 32'(fl[i].st));
      chk("flash_grst",  32'(game_rst),  32'(fl[i].grst));
      chk("flash_arena", 32'(arena_out), 32'(fl[i].arena));
    end

`ifdef WORMY_SEQ_SCORE_EN
    x = d + 64;
    goto_edge(x + 63);
    chk("score_hold", 32'(seq_state), 32'd3);
    goto_edge(x + 64);
    chk("score_timeout", 32'(seq_state), 32'd0);
    chk("score_to_grst", 32'(game_rst), 32'd1);
    chk("score_to_arena", 32'(arena_out), 32'h0001);

    p = edge_n + 1;
    press_at(p);
    s = first_step(p, 6);
    exp_q.push_back(s);
    goto_edge(s + 23);
    game_over = 1'b1;
    goto_edge(s + 24);
    game_over = 1'b0;
    chk("dead2_state", 32'(seq_state), 32'd2);
    x = s + 24 + 64;
    goto_edge(x);
    chk("score2_state", 32'(seq_state), 32'd3);
    worm_len = 5'd0;  #1; chk("therm0",  32'(arena_out), 32'h0000);
    worm_len = 5'd16; #1; chk("therm16", 32'(arena_out), 32'hFFFF);
    worm_len = 5'd9;  #1; chk("therm9",  32'(arena_out), 32'h01FF);
    worm_len = 5'd1;  #1; chk("therm1",  32'(arena_out), 32'h0001);
    worm_len = 5'd5;
    goto_edge(x + 11);
    chk("score_pre_press", 32'(seq_state), 32'd3);
    press_at(x + 12);
    chk("score_press_exit", 32'(seq_state), 32'd0);
    chk("score_press_grst", 32'(game_rst), 32'd1);
`endif

    p = edge_n + 1;
    press_at(p);
    chk("rerun_state", 32'(seq_state), 32'd1);
    goto_edge(p + 20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_state", 32'(seq_state), 32'd0);
    chk("midrst_grst",  32'(game_rst),  32'd1);
    chk("midrst_step",  32'(step),      32'd0);
    chk("midrst_arena", 32'(arena_out), 32'h0001);
    goto_edge(100);

    chk("steps_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
